// File: rtl/wshb_pkg.sv
// Shared types and constants for the Wishbone RAM responder: FSM states,
// cycle-type / burst-type codes and the address legality rule.
package wshb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wshb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Misaligned or beyond the top of a 4*2^depth_width byte space.
    function automatic logic addr_illegal(input logic [31:0] a, input int depth_width);
        logic [32:0] limit;
        limit = 33'd4 << depth_width;
        return (a[1:0] != 2'b00) || ({1'b0, a} >= limit);
    endfunction

endpackage

// File: rtl/be_ram.sv
// Byte-lane-enabled single-clock RAM with one write port and a registered
// read port; the read register only updates when re is high.
module be_ram #(
    parameter int DEPTH_WIDTH = 10,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DEPTH_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [DEPTH_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<DEPTH_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 classic RAM responder with programmable wait states and err on
// illegal addresses. Linear incrementing bursts are added by WSHB_RAM_BURST_EN.
module wshb_ram_slave
    import wshb_pkg::*;
#(
    parameter int DEPTH_WIDTH = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic [31:0] dat_sm,
    output logic        ack,
    output logic        err,
    output logic        rty,
    output wshb_state_e dbg_state
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    wshb_state_e state_q;
    logic [3:0]  cnt_q;
    logic        ack_q, err_q;
    logic [31:0] adr_q, dat_q;
    logic [3:0]  sel_q;
    logic        we_q, bad_q, burst_q, valid_q;

    logic        req, req_bad, burst_go, next_bad, rd_en;
    logic [31:0] next_adr, rd_adr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic        unused_bits;

    // The read address is steered combinationally so the RAM register holds
    // the right word in the very cycle ack rises, including every burst beat.
    always_comb begin
        req      = cyc & stb;
        req_bad  = addr_illegal(adr, DEPTH_WIDTH);
        next_adr = adr_q + 32'd4;
        next_bad = addr_illegal(next_adr, DEPTH_WIDTH);
`ifdef WSHB_RAM_BURST_EN
        burst_go = (state_q == RESP) && req && (cti == CTI_INCR) &&
                   (bte == BTE_LINEAR) && !bad_q;
`else
        burst_go = 1'b0;
`endif
        rd_en  = 1'b0;
        rd_adr = adr_q;
        case (state_q)
            IDLE: begin
                rd_adr = adr;
                rd_en  = req && !we && !req_bad && (WS == 4'd0);
            end
            WAIT: rd_en = cyc && (cnt_q <= 4'd1) && !we_q && !bad_q;
            RESP: begin
                rd_adr = next_adr;
                rd_en  = burst_go && !we_q && !next_bad;
            end
            default: ;
        endcase
    end

    // Later burst beats take data straight from the bus, which the master
    // holds for the beat currently being acknowledged.
    assign ram_we    = (state_q == RESP && we_q && !bad_q) ? (burst_q ? sel : sel_q) : 4'b0000;
    assign ram_wdata = burst_q ? dat_ms : dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            burst_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (rd_en) begin
                valid_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    burst_q <= 1'b0;
                    if (req) begin
                        adr_q <= adr;
                        dat_q <= dat_ms;
                        sel_q <= sel;
                        we_q  <= we;
                        bad_q <= req_bad;
                        cnt_q <= WS;
                        if (WS == 4'd0) begin
                            state_q <= RESP;
                            ack_q   <= !req_bad;
                            err_q   <= req_bad;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!cyc) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= RESP;
                        cnt_q   <= 4'd0;
                        ack_q   <= !bad_q;
                        err_q   <= bad_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (burst_go) begin
                        adr_q   <= next_adr;
                        bad_q   <= next_bad;
                        ack_q   <= !next_bad;
                        err_q   <= next_bad;
                        burst_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        burst_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    be_ram #(
        .DEPTH_WIDTH (DEPTH_WIDTH),
        .DATA_WIDTH  (32)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (adr_q[DEPTH_WIDTH+1:2]),
        .wdata (ram_wdata),
        .re    (rd_en),
        .raddr (rd_adr[DEPTH_WIDTH+1:2]),
        .rdata (ram_rdata)
    );

    // Until the first legal read the RAM register is undefined; present zero.
    assign dat_sm    = valid_q ? ram_rdata : 32'd0;
    assign ack       = ack_q;
    assign err       = err_q;
    assign rty       = 1'b0;
    assign dbg_state = state_q;

    assign unused_bits = ^{cti, bte, rd_adr[1:0], rd_adr[31:DEPTH_WIDTH+2]};

endmodule

// File: doc/wshb_ram_slave.md
# wshb_ram_slave

On-chip RAM exposed as a Wishbone B4 classic responder: the slave end of the bus that the video and pattern masters drive. It serves 32-bit reads and byte-selected writes with a programmable number of wait states, and flags out-of-range or misaligned accesses with `err`. It is used as a framebuffer stand-in on the `wshb_if` bus for simulation and for small on-FPGA frames. An optional linear-burst mode lets a streaming reader pull one word per cycle.

## Interface
- `DEPTH_WIDTH`, 10: log2 of the number of 32-bit words; byte address space is 4·2^DEPTH_WIDTH.
- `WAIT_STATES`, 1: extra cycles inserted before `ack`/`err` on a classic access; legal range 0..15.
- `clk` in 1: bus clock; every register is clocked on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cyc` in 1: bus cycle valid.
- `stb` in 1: strobe.
- `we` in 1: 1 = write, 0 = read.
- `sel` in 4: byte enables; bit i enables `dat_ms[8i+7:8i]`.
- `adr` in 32: byte address.
- `dat_ms` in 32: write data.
- `cti` in 3: cycle type identifier; only used when bursts are compiled in.
- `bte` in 2: burst type extension; only used when bursts are compiled in.
- `dat_sm` out 32: read data.
- `ack` out 1: normal termination, registered.
- `err` out 1: error termination, registered.
- `rty` out 1: tied to 0.

## Operation
- A request is `cyc & stb` sampled high while the block is in IDLE.
- Word index is `adr[DEPTH_WIDTH+1:2]`.
- An access is illegal if `adr[1:0] != 0` or if `adr >= 4·2^DEPTH_WIDTH`. An illegal access terminates with `err` instead of `ack`, performs no RAM write, and leaves `dat_sm` unchanged.
- State machine:
  - IDLE: on a request, load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES > 0, otherwise go to RESP.
  - WAIT: decrement the counter each cycle. Go to RESP when it reaches 1. If `cyc` drops, go to IDLE with no termination and no write.
  - RESP: `ack` (or `err`) is high for this cycle. A write commits at the end of this cycle using the sampled `sel`. Then go to IDLE.
- After RESP there is one dead IDLE cycle before the next request is sampled, so a held `stb` is never acknowledged twice.
- Reads ignore `sel` and always return the full word.
- Writes with `sel` = 0000 are still acknowledged but change no bytes.

## Timing
- Reset values: `ack`=0, `err`=0, `rty`=0, `dat_sm`=0, state IDLE, counter 0. RAM contents are not cleared.
- Classic latency: with the request sampled at edge k, `ack`/`err` is high in the cycle after edge k+WAIT_STATES. Minimum latency is 1 cycle.
- Classic throughput: one access per WAIT_STATES+2 cycles.
- `dat_sm` holds valid read data in every cycle in which `ack` is high, and holds that value until the next read ack.
- A write becomes visible to a read sampled on the edge after its ack.
- If `rst` is asserted mid-access, `ack` and `err` drop immediately (asynchronously) and the pending write is discarded.
- If `cyc` drops in the same cycle as RESP, the write still commits: termination was already driven.

## Configuration
- Macro: `WSHB_RAM_BURST_EN`.
- Defined: in RESP, if `cyc & stb`, `cti`=3'b010 and `bte`=2'b00 (linear burst), stay in RESP and ack the next address (+4) every cycle. The RAM read address is driven with the next word combinationally, so there is zero wait between beats.
  - `cti`=3'b111 marks the last beat; the block returns to IDLE after it.
  - A beat that crosses the top of memory ends with `err` on that beat, then the block returns to IDLE.
  - Any other `cti`/`bte` value is handled as classic.
- Undefined: `cti` and `bte` are ignored and every access is classic.

## Structure
- `wshb_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - BTE_LINEAR=2'b00.
- One sub-module, `be_ram`:
  - parameters DEPTH_WIDTH and 32-bit width;
  - 4 byte lanes with individual write enables;
  - synchronous read with one-cycle latency.

## Test plan
- Write 32'hDEADBEEF to 0x10 with `sel`=1111, then read 0x10. Required: each `ack` arrives 2 cycles after the request (WAIT_STATES=1), and the read returns 32'hDEADBEEF.
- Write 32'h000000AA to 0x10 with `sel`=0001, then read 0x10. Required: the read returns 32'hDEADBEAA.
- Read 0x1002 (misaligned), then read 0x1000 (out of range with DEPTH_WIDTH=10). Required: one-cycle `err` each time, no `ack`, `dat_sm` unchanged.
- Drop `cyc` in the WAIT cycle of a write to 0x20, then read 0x20. Required: no termination for the aborted write, and the read returns the old contents.
- Assert `rst` during WAIT. Required: `ack`/`err` low immediately and state IDLE; the next request behaves normally.
- With `WSHB_RAM_BURST_EN`, read from 0x0 with `cti`=010 ×3 then 111, with memory preloaded to 0,1,2,3. Required: `ack` on 4 consecutive cycles with data 0,1,2,3, then IDLE.
